lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Receive-side checker for the 16-bit Fibonacci LFSR test pattern (taps 16,14,13,11) that the test source emits while host data is not yet available. The block sits at the far end of the datapath. It self-synchronises to the incoming word stream, declares lock, then counts words and mismatches so link and datapath integrity can be measured without a reference copy of the seed.

## Interface
Parameters:
- LOCK_COUNT, default 4: consecutive correctly-predicted words required in VERIFY before lock is declared.
- LOSS_COUNT, default 3: consecutive mismatches in LOCKED that cause loss of lock.
- CNT_WIDTH, default 32: width of the word and error counters.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data_valid  in  1  data_in carries a word this cycle.
- data_in  in  16  received LFSR word.
- clear  in  1  synchronous; zeroes both counters; lock state unchanged.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched word while LOCKED.
- err_count  out  CNT_WIDTH  mismatches while LOCKED, saturating.
- word_count  out  CNT_WIDTH  valid words while LOCKED, saturating.

## Operation
- Next-state function: next(s) = {s[14:0], s[15]^s[13]^s[12]^s[10]}. It must be bit-identical to the generator.
- A predictor register `pred` holds the expected value of the next valid word.
- Cycles with data_valid=0 change no state and no counter.
- States:
  - HUNT, entered on reset:
    - Valid nonzero word w: pred<=next(w), match counter<=0, go to VERIFY.
    - Valid zero word: ignored, because zero is an illegal LFSR state.
  - VERIFY, on each valid word w:
    - w==pred: pred<=next(pred), increment match counter. When the counter reaches LOCK_COUNT, go to LOCKED.
    - Mismatch: reseed from w in this same cycle, following the HUNT rules. This includes dropping back to HUNT if w==0.
  - LOCKED, on each valid word:
    - pred always advances from the predicted value, pred<=next(pred), never from the received word. An isolated corrupted word therefore costs exactly one error.
    - Match: clear the consecutive-miss counter.
    - Mismatch: err_pulse, err_count+1, miss counter+1. When the miss counter reaches LOSS_COUNT, go to HUNT. The mismatch that causes loss is still counted.
    - word_count increments on every valid word, whether it matches or not.
- Counters saturate at all-ones. clear takes priority over an increment in the same cycle.
- Async reset values: state=HUNT, pred=0, locked=0, err_pulse=0, err_count=0, word_count=0, and the match and miss counters=0.
- Reset asserted mid-stream: the block returns to HUNT immediately, and lock is re-acquired from the first nonzero word after reset is released.

## Timing
- All outputs are registered.
- err_pulse, counter updates and locked rise/fall are visible on the cycle after the edge that samples the word causing them.
- Lock latency: with a clean, back-to-back stream, locked rises 1+LOCK_COUNT valid words after the first nonzero word. With default parameters, locked is seen in the cycle after the 5th valid word is sampled.
- Unlock latency: locked falls in the cycle after the LOSS_COUNT-th consecutive mismatch is sampled.
- Gaps in data_valid only stretch these latencies; they never reset progress.
- The design must sustain one word per clock with no back-pressure.

## Structure
- Shared package `lfsr_pkg`:
  - localparams LFSR_WIDTH=16 and the tap positions.
  - Function `lfsr_next`.
  - The state typedef/encodings (HUNT, VERIFY, LOCKED).
- The generator adopts the same function so the two ends cannot diverge.
- Natural sub-module: `sat_counter`, a CNT_WIDTH saturating counter with inc and clear inputs, instantiated twice.

## Test plan
- **Clean lock:** reset_n low then high; stream 0x0010, 0x0020, 0x0040, 0x0080, 0x0100, 0x0200, 0x0400, 0x0801, continuing the sequence -> locked=1 after the 5th word; word_count counts from the 6th word; err_count stays 0.
- **Single error:** once locked, replace one word with its value XOR 0x0001 -> exactly one err_pulse; err_count=1; locked stays 1; no further errors on the following correct words.
- **Loss of lock:** once locked, inject 3 consecutive corrupted words -> err_count=3; locked falls after the 3rd. Resume the correct sequence -> relock after 5 valid words.
- **Zero and gaps:** in HUNT, send 0x0000 three times -> stay in HUNT. Then send the clean sequence with data_valid deasserted every other cycle -> lock after 5 valid words.
- **Counters:** force word_count near all-ones (CNT_WIDTH=4 build) -> it saturates at 0xF. Assert clear together with a mismatching word -> both counters read 0.
- **Reset mid-lock:** while locked with err_count=2, pulse reset_n low asynchronously between edges -> all outputs go to 0 immediately; the block relocks on the stream that follows.

Source files
------------

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared definitions for the 16-bit Fibonacci LFSR test
//               pattern (taps 16,14,13,11). Used by both the pattern
//               generator and the receive-side checker so that the two ends
//               cannot diverge.
// Contents    : LFSR_WIDTH, tap positions, lfsr_next(), checker state enum
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  localparam int LFSR_WIDTH = 16;

  // Tap positions, 1-based as in the polynomial x^16 + x^14 + x^13 + x^11 + 1
  localparam int TAP_A = 16;
  localparam int TAP_B = 14;
  localparam int TAP_C = 13;
  localparam int TAP_D = 11;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  // Shift left, feed the XOR of the taps into bit 0.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
    lfsr_next = {s[LFSR_WIDTH-2:0],
                 s[TAP_A-1] ^ s[TAP_B-1] ^ s[TAP_C-1] ^ s[TAP_D-1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter. Holds at all-ones once reached.
//               A synchronous clear wins over an increment in the same cycle.
// Ports       : clk     - clock (rising edge)
//               reset_n - asynchronous active-low reset
//               inc     - count up by one this cycle
//               clear   - synchronous clear to zero
//               count   - registered count value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_checker
// Description : Receive-side checker for the 16-bit LFSR test pattern.
//               Self-synchronises on the incoming stream (HUNT -> VERIFY ->
//               LOCKED), then counts words and mismatches while locked.
// Ports       : clk        - clock (rising edge)
//               reset_n    - asynchronous active-low reset
//               data_valid - data_in carries a word this cycle
//               data_in    - received LFSR word
//               clear      - synchronous clear of both counters
//               locked     - checker is in LOCKED (registered)
//               err_pulse  - one-cycle pulse per mismatch while LOCKED
//               err_count  - saturating mismatch count while LOCKED
//               word_count - saturating valid-word count while LOCKED
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  data_valid,
  input  logic [LFSR_WIDTH-1:0] data_in,
  input  logic                  clear,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int MATCH_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = (LOSS_COUNT < 2) ? 1 : $clog2(LOSS_COUNT + 1);

  // Counter values on the word *before* the threshold is reached; the
  // current word then completes the run.
  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]  LOSS_LAST = MISS_W'(LOSS_COUNT - 1);

  lfsr_state_e           state_q, state_d;
  logic [LFSR_WIDTH-1:0] pred_q, pred_d;
  logic [MATCH_W-1:0]    match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]     miss_cnt_q, miss_cnt_d;
  logic                  locked_q, locked_d;
  logic                  err_pulse_q, err_pulse_d;

  logic                  word_inc;
  logic                  err_inc;
  logic                  word_match;
  logic                  word_nonzero;

  assign word_match   = (data_in == pred_q);
  assign word_nonzero = |data_in;

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_pulse_d = 1'b0;
    word_inc    = 1'b0;
    err_inc     = 1'b0;

    if (data_valid) begin
      case (state_q)
        HUNT: begin
          // Zero is not a reachable LFSR state, so it cannot seed.
          if (word_nonzero) begin
            pred_d      = lfsr_next(data_in);
            match_cnt_d = '0;
            state_d     = VERIFY;
          end
        end

        VERIFY: begin
          if (word_match) begin
            pred_d = lfsr_next(pred_q);
            if (match_cnt_q == LOCK_LAST) begin
              match_cnt_d = '0;
              miss_cnt_d  = '0;
              state_d     = LOCKED;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else if (word_nonzero) begin
            // Reseed immediately from the received word.
            pred_d      = lfsr_next(data_in);
            match_cnt_d = '0;
          end else begin
            match_cnt_d = '0;
            state_d     = HUNT;
          end
        end

        LOCKED: begin
          // Free-run from the prediction so a single corrupted word
          // costs exactly one error rather than two.
          pred_d   = lfsr_next(pred_q);
          word_inc = 1'b1;
          if (word_match) begin
            miss_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            if (miss_cnt_q == LOSS_LAST) begin
              miss_cnt_d = '0;
              state_d    = HUNT;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      pred_q      <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (err_inc),
    .clear   (clear),
    .count   (err_count)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_word_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (word_inc),
    .clear   (clear),
    .count   (word_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_checker
// Description : Self-checking bench for lfsr_checker. A default build and a
//               CNT_WIDTH=4 build receive the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        data_valid = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        clear = 1'b0;

  logic        locked, err_pulse;
  logic [31:0] err_count, word_count;
  logic        locked4, err_pulse4;
  logic [3:0]  err_count4, word_count4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] g;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_valid (data_valid),
    .data_in    (data_in),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .word_count (word_count)
  );

  lfsr_checker #(.CNT_WIDTH(4)) dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_valid (data_valid),
    .data_in    (data_in),
    .clear      (clear),
    .locked     (locked4),
    .err_pulse  (err_pulse4),
    .err_count  (err_count4),
    .word_count (word_count4)
  );

  // Independent model of the pattern: feedback is the parity of the tap mask.
  function automatic logic [15:0] nxt(input logic [15:0] s);
    nxt = {s[14:0], ^(s & 16'hB400)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic chk_all(input string tag, input logic lk, input logic er,
                         input int wc, input int ec);
    check({tag, ".locked"},     {31'd0, locked},    {31'd0, lk});
    check({tag, ".err_pulse"},  {31'd0, err_pulse}, {31'd0, er});
    check({tag, ".word_count"}, word_count,         wc);
    check({tag, ".err_count"},  err_count,          ec);
  endtask

  // Called at a falling edge: drive, let one rising edge sample, return at
  // the next falling edge with outputs settled.
  task automatic step(input logic v, input logic [15:0] d, input logic clr);
    data_valid = v;
    data_in    = d;
    clear      = clr;
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    clear      = 1'b0;
  endtask

  // Send the next pattern word (optionally corrupted); the pattern advances
  // either way.
  task automatic send_word(input logic corrupt);
    step(1'b1, g ^ {15'd0, corrupt}, 1'b0);
    g = nxt(g);
  endtask

  typedef struct {
    logic corrupt;
    logic exp_locked;
    logic exp_err;
    int   exp_wc;
    int   exp_ec;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Clean lock then a single corrupted word.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 2, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 3, 0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 4, 0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 5, 1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 6, 1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 7, 1};

    // ---------------- reset ----------------
    repeat (2) @(negedge clk);
    chk_all("reset", 1'b0, 1'b0, 0, 0);
    check("reset.word_count4", {28'd0, word_count4}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // First words of the pattern, derived by hand.
    g = 16'h0010;
    check("model.w8", {16'd0, nxt(nxt(nxt(nxt(nxt(nxt(nxt(g)))))))}, 32'h0801);

    // ---------------- table: clean lock + single error ----------------
    for (int i = 0; i < 12; i++) begin
      send_word(tbl[i].corrupt);
      chk_all($sformatf("tbl%0d", i), tbl[i].exp_locked, tbl[i].exp_err,
              tbl[i].exp_wc, tbl[i].exp_ec);
    end

    // ---------------- clear, then loss of lock ----------------
    step(1'b0, 16'h0000, 1'b1);
    chk_all("clear_idle", 1'b1, 1'b0, 0, 0);
    send_word(1'b1);
    chk_all("loss1", 1'b1, 1'b1, 1, 1);
    send_word(1'b1);
    chk_all("loss2", 1'b1, 1'b1, 2, 2);
    send_word(1'b1);
    chk_all("loss3", 1'b0, 1'b1, 3, 3);
    for (int i = 1; i <= 5; i++) begin
      send_word(1'b0);
      chk_all($sformatf("relock%0d", i), (i == 5), 1'b0, 3, 3);
    end

    // ---------------- zeros in HUNT, then gapped stream ----------------
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'h0000, 1'b0);
      check($sformatf("zero%0d.locked", i), {31'd0, locked}, 32'd0);
    end
    g = 16'h0010;
    for (int i = 1; i <= 5; i++) begin
      send_word(1'b0);
      check($sformatf("gap_w%0d.locked", i), {31'd0, locked}, {31'd0, (i == 5)});
      step(1'b0, 16'hFFFF, 1'b0);
      check($sformatf("gap_i%0d.locked", i), {31'd0, locked}, {31'd0, (i == 5)});
    end

    // ---------------- saturation (4-bit build) ----------------
    for (int n = 1; n <= 20; n++) begin
      send_word(1'b0);
      check($sformatf("sat%0d.word_count", n), word_count, n);
      check($sformatf("sat%0d.word_count4", n), {28'd0, word_count4},
            (n > 15) ? 32'd15 : n);
    end

    // clear together with a mismatching word
    step(1'b1, g ^ 16'h0001, 1'b1);
    g = nxt(g);
    check("clr_mis.word_count", word_count, 32'd0);
    check("clr_mis.err_count", err_count, 32'd0);
    check("clr_mis.word_count4", {28'd0, word_count4}, 32'd0);
    check("clr_mis.locked", {31'd0, locked}, 32'd1);
    send_word(1'b0);
    chk_all("post_clr", 1'b1, 1'b0, 1, 0);

    // ---------------- reset mid-lock ----------------
    send_word(1'b1);
    send_word(1'b0);
    send_word(1'b1);
    chk_all("pre_rst", 1'b1, 1'b1, 4, 2);
    #2 reset_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send_word(1'b0);
      check($sformatf("rst_relock%0d.locked", i), {31'd0, locked}, {31'd0, (i == 5)});
    end
    send_word(1'b0);
    chk_all("rst_after", 1'b1, 1'b0, 1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
